// File: rtl/async_fifo_wr_ctrl_if.sv
// Write-side bundle of the dual-clock FIFO: producer handshake, RAM write port
// and the Gray pointers exchanged with the read domain.
interface async_fifo_wr_ctrl_if #(
  parameter int SIZE = 3
);
  logic            wr_req;
  logic [SIZE:0]   rd_ptr_gray;
  logic            wr_en;
  logic [SIZE-1:0] wrt_ptr;
  logic [SIZE:0]   wr_ptr_gray;
  logic            full;
  logic            almost_full;
  logic [SIZE:0]   wr_level;
  logic            overflow;

  modport master (
    output wr_req, rd_ptr_gray,
    input  wr_en, wrt_ptr, wr_ptr_gray, full, almost_full, wr_level, overflow
  );

  modport slave (
    input  wr_req, rd_ptr_gray,
    output wr_en, wrt_ptr, wr_ptr_gray, full, almost_full, wr_level, overflow
  );
endinterface

// File: rtl/async_fifo_wr_ctrl.sv
// Write-domain controller of the dual-clock FIFO: write pointer/address generation,
// read-pointer synchronisation and pessimistic full/almost-full/level flags.
module async_fifo_wr_ctrl #(
  parameter int SIZE         = 3,
  parameter int AFULL_MARGIN = 2
) (
  input logic                 wr_clk,
  input logic                 rst,
  async_fifo_wr_ctrl_if.slave bus
);

  localparam logic [SIZE:0] AFULL_THR = (SIZE+1)'(2**SIZE - AFULL_MARGIN);

  function automatic logic [SIZE:0] bin2gray(input logic [SIZE:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [SIZE:0] gray2bin(input logic [SIZE:0] g);
    logic [SIZE:0] b;
    b[SIZE] = g[SIZE];
    for (int i = SIZE - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [SIZE:0] wr_bin_r;
  logic [SIZE:0] wr_gray_r;
  logic [SIZE:0] rd_s1_r;
  logic [SIZE:0] rd_s2_r;
  logic          full_r;
  logic          almost_full_r;
  logic [SIZE:0] wr_level_r;
  logic          overflow_r;

  logic          wr_en_s;
  logic [SIZE:0] wr_bin_next_s;
  logic [SIZE:0] wr_gray_next_s;
  logic [SIZE:0] rd_bin_next_s;
  logic          full_next_s;
  logic          almost_full_next_s;
  logic [SIZE:0] wr_level_next_s;

  // Push acceptance; reset gating keeps the RAM quiet before the flags are valid.
  always_comb begin
    wr_en_s = bus.wr_req & ~full_r & ~rst;
  end

  // Next-state pointers and flags; rd_s1_r is the value rd_s2 loads this edge.
  // Flags only need recomputing when the write pointer or the synchronised read
  // pointer actually moves; otherwise they already equal f(wr_bin_r, rd_s2_r).
  always_comb begin
    wr_bin_next_s      = wr_bin_r + {{SIZE{1'b0}}, wr_en_s};
    wr_gray_next_s     = bin2gray(wr_bin_next_s);
    rd_bin_next_s      = gray2bin(rd_s1_r);
    full_next_s        = full_r;
    wr_level_next_s    = wr_level_r;
    almost_full_next_s = almost_full_r;
    if (wr_en_s || (rd_s1_r != rd_s2_r)) begin
      full_next_s        = (wr_gray_next_s == {~rd_s1_r[SIZE:SIZE-1], rd_s1_r[SIZE-2:0]});
      wr_level_next_s    = wr_bin_next_s - rd_bin_next_s;
      almost_full_next_s = (wr_level_next_s >= AFULL_THR);
    end else begin
      full_next_s        = full_r;
      wr_level_next_s    = wr_level_r;
      almost_full_next_s = almost_full_r;
    end
  end

  // State registers: pointers, synchroniser stages, flags and sticky overflow.
  always_ff @(posedge wr_clk) begin
    if (rst) begin
      wr_bin_r      <= '0;
      wr_gray_r     <= '0;
      rd_s1_r       <= '0;
      rd_s2_r       <= '0;
      full_r        <= 1'b0;
      almost_full_r <= 1'b0;
      wr_level_r    <= '0;
      overflow_r    <= 1'b0;
    end else begin
      wr_bin_r      <= wr_bin_next_s;
      wr_gray_r     <= wr_gray_next_s;
      rd_s1_r       <= bus.rd_ptr_gray;
      rd_s2_r       <= rd_s1_r;
      full_r        <= full_next_s;
      almost_full_r <= almost_full_next_s;
      wr_level_r    <= wr_level_next_s;
      overflow_r    <= overflow_r | (bus.wr_req & full_r);
    end
  end

  assign bus.wr_en       = wr_en_s;
  assign bus.wrt_ptr     = wr_bin_r[SIZE-1:0];
  assign bus.wr_ptr_gray = wr_gray_r;
  assign bus.full        = full_r;
  assign bus.almost_full = almost_full_r;
  assign bus.wr_level    = wr_level_r;
  assign bus.overflow    = overflow_r;

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// Scoreboard bench for async_fifo_wr_ctrl (SIZE=3, AFULL_MARGIN=2): the driver queues
// hand-computed expectations per cycle, the monitor pops and compares them.
module tb_async_fifo_wr_ctrl;

  logic wr_clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  async_fifo_wr_ctrl_if #(.SIZE(3)) bus ();

  async_fifo_wr_ctrl #(.SIZE(3), .AFULL_MARGIN(2)) dut (
    .wr_clk (wr_clk),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 wr_clk = ~wr_clk;

  typedef struct {
    string      name;
    bit         gmode;
    logic       en;
    logic [2:0] ptr;
    logic [3:0] gray;
    logic       full;
    logic       af;
    logic [3:0] lvl;
    logic       ovf;
  } exp_t;

  exp_t q[$];

  // Gray codes of 0..11, written out by hand
  logic [3:0] gtab [0:11] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
                              4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110};

  function automatic logic [3:0] g4(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic exp_t mk(input string n, input bit gm, input logic en, input logic [2:0] ptr,
                              input logic [3:0] gray, input logic full, input logic af,
                              input logic [3:0] lvl, input logic ovf);
    exp_t e;
    e.name = n; e.gmode = gm; e.en = en; e.ptr = ptr; e.gray = gray;
    e.full = full; e.af = af; e.lvl = lvl; e.ovf = ovf;
    return e;
  endfunction

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic cyc(input logic rs, input logic req, input logic [3:0] rdg, input exp_t e);
    @(negedge wr_clk);
    rst             = rs;
    bus.wr_req      = req;
    bus.rd_ptr_gray = rdg;
    q.push_back(e);
  endtask

  task automatic fill8(input string n);
    for (int k = 1; k <= 8; k++) begin
      cyc(1'b0, 1'b1, 4'b0000, mk(n, 1'b0, 1'b1, 3'(k), gtab[k], 1'(k == 8), 1'(k >= 6), 4'(k), 1'b0));
    end
  endtask

  // Monitor: wr_en sampled mid-cycle, registered outputs 1 time unit after the edge.
  initial begin
    exp_t       e;
    logic       en_a;
    logic [3:0] prev_g;
    prev_g = 4'b0000;
    forever begin
      @(negedge wr_clk);
      #2;
      if (q.size() > 0) begin
        en_a = bus.wr_en;
        e    = q.pop_front();
        @(posedge wr_clk);
        #1;
        chk({e.name, ".wr_en"}, int'(en_a), int'(e.en));
        chk({e.name, ".wr_ptr_gray"}, int'(bus.wr_ptr_gray), int'(e.gray));
        if (e.gmode) begin
          chk({e.name, ".gray_step_le1"}, int'($countones(prev_g ^ bus.wr_ptr_gray) <= 1), 1);
        end else begin
          chk({e.name, ".wrt_ptr"}, int'(bus.wrt_ptr), int'(e.ptr));
          chk({e.name, ".full"}, int'(bus.full), int'(e.full));
          chk({e.name, ".almost_full"}, int'(bus.almost_full), int'(e.af));
          chk({e.name, ".wr_level"}, int'(bus.wr_level), int'(e.lvl));
          chk({e.name, ".overflow"}, int'(bus.overflow), int'(e.ovf));
        end
        prev_g = bus.wr_ptr_gray;
      end
    end
  end

  // Driver: directed scenarios, then a random-push Gray property run.
  initial begin
    logic [3:0] n;
    logic       req;
    rst             = 1'b1;
    bus.wr_req      = 1'b1;
    bus.rd_ptr_gray = 4'b0000;

    cyc(1'b1, 1'b1, 4'b0000, mk("reset1", 1'b0, 1'b0, 3'd0, 4'b0000, 1'b0, 1'b0, 4'd0, 1'b0));
    cyc(1'b1, 1'b1, 4'b0000, mk("reset2", 1'b0, 1'b0, 3'd0, 4'b0000, 1'b0, 1'b0, 4'd0, 1'b0));

    fill8("fill");
    cyc(1'b0, 1'b1, 4'b0000, mk("fill9_refused", 1'b0, 1'b0, 3'd0, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b1));

    cyc(1'b0, 1'b0, 4'b0010, mk("drain_e1", 1'b0, 1'b0, 3'd0, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b1));
    cyc(1'b0, 1'b0, 4'b0010, mk("drain_e2", 1'b0, 1'b0, 3'd0, 4'b1100, 1'b0, 1'b0, 4'd5, 1'b1));

    cyc(1'b1, 1'b1, 4'b0000, mk("rst_clears_ovf", 1'b0, 1'b0, 3'd0, 4'b0000, 1'b0, 1'b0, 4'd0, 1'b0));
    for (int k = 1; k <= 5; k++) begin
      cyc(1'b0, 1'b1, 4'b0000, mk("midfill", 1'b0, 1'b1, 3'(k), gtab[k], 1'b0, 1'b0, 4'(k), 1'b0));
    end
    cyc(1'b1, 1'b1, 4'b0000, mk("midfill_rst", 1'b0, 1'b0, 3'd0, 4'b0000, 1'b0, 1'b0, 4'd0, 1'b0));
    cyc(1'b0, 1'b1, 4'b0000, mk("after_rst_push", 1'b0, 1'b1, 3'd1, 4'b0001, 1'b0, 1'b0, 4'd1, 1'b0));

    cyc(1'b1, 1'b0, 4'b0000, mk("wrap_rst", 1'b0, 1'b0, 3'd0, 4'b0000, 1'b0, 1'b0, 4'd0, 1'b0));
    fill8("wrap_fill");
    cyc(1'b0, 1'b0, 4'b1100, mk("wrap_rd_e1", 1'b0, 1'b0, 3'd0, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b0));
    cyc(1'b0, 1'b0, 4'b1100, mk("wrap_rd_e2", 1'b0, 1'b0, 3'd0, 4'b1100, 1'b0, 1'b0, 4'd0, 1'b0));
    cyc(1'b0, 1'b1, 4'b1100, mk("wrap_p1", 1'b0, 1'b1, 3'd1, 4'b1101, 1'b0, 1'b0, 4'd1, 1'b0));
    cyc(1'b0, 1'b1, 4'b1100, mk("wrap_p2", 1'b0, 1'b1, 3'd2, 4'b1111, 1'b0, 1'b0, 4'd2, 1'b0));
    cyc(1'b0, 1'b1, 4'b1100, mk("wrap_p3", 1'b0, 1'b1, 3'd3, 4'b1110, 1'b0, 1'b0, 4'd3, 1'b0));

    // Reader tracks the writer, so the FIFO never fills and every request is taken
    n = 4'd11;
    for (int c = 0; c < 64; c++) begin
      req = 1'($urandom_range(0, 1));
      cyc(1'b0, req, g4(n), mk("gray_prop", 1'b1, req, 3'd0, g4(n + {3'b000, req}), 1'b0, 1'b0, 4'd0, 1'b0));
      n = n + {3'b000, req};
    end

    repeat (3) @(negedge wr_clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/async_fifo_wr_ctrl.md
# async_fifo_wr_ctrl

Write-domain controller for the dual-clock FIFO; sits directly upstream of the dual-clock storage RAM. It accepts push requests, produces the RAM write enable and binary write address, and publishes a Gray-coded write pointer for the read domain. It also synchronises the read domain's Gray pointer into wr_clk to generate full, almost-full, fill level and a sticky overflow flag.

## Interface
- SIZE, 3 — address width; FIFO depth = 2**SIZE entries; SIZE >= 2
- AFULL_MARGIN, 2 — almost_full asserts when level >= 2**SIZE - AFULL_MARGIN; range 1..2**SIZE-1
- wr_clk  in  1  write-domain clock
- rst  in  1  synchronous, active-high reset
- wr_req  in  1  push request from the producer
- rd_ptr_gray  in  SIZE+1  read pointer, Gray-coded, driven from the rd_clk domain (asynchronous to wr_clk)
- wr_en  out  1  RAM write enable; wr_req & ~full, combinational
- wrt_ptr  out  SIZE  RAM write address (binary, registered)
- wr_ptr_gray  out  SIZE+1  write pointer, Gray-coded, registered, for the read domain
- full  out  1  FIFO full, registered
- almost_full  out  1  level threshold flag, registered
- wr_level  out  SIZE+1  fill level as seen from the write domain, registered, 0..2**SIZE
- overflow  out  1  sticky: a push was attempted while full

## Operation
- Internal state:
  - wr_bin, SIZE+1 bits: binary write pointer.
  - wr_gray: equals wr_bin ^ (wr_bin >> 1), stored as a register.
  - rd_s1 and rd_s2: two-flop synchroniser on rd_ptr_gray; no logic between the stages.
- Push accepted: wr_en = 1 when wr_req=1 and full=0. On that edge:
  - wr_bin increments modulo 2**(SIZE+1).
  - wr_gray updates to the Gray code of the new wr_bin.
- wrt_ptr = wr_bin[SIZE-1:0]. It wraps 2**SIZE-1 -> 0; the wrap bit lives only in wr_bin[SIZE].
- rd_bin_s is the Gray-to-binary conversion of the synchronised read pointer:
  - rd_bin_s[SIZE] = g[SIZE].
  - rd_bin_s[i] = rd_bin_s[i+1] ^ g[i].
- Flags are registered from next-state values: wr_gray_next and the value loading into rd_s2 this edge.
  - full_next = (wr_gray_next == {~rd_s2_next[SIZE:SIZE-1], rd_s2_next[SIZE-2:0]}).
  - wr_level_next = wr_bin_next - rd_bin_s_next, SIZE+1-bit modular subtraction.
  - almost_full_next = (wr_level_next >= 2**SIZE - AFULL_MARGIN).
- overflow sets on any edge where wr_req=1 and full=1; only rst clears it. A refused push does not move any pointer.
- Flags are pessimistic, never optimistic:
  - full may remain high up to 2 cycles after the reader frees space.
  - full never deasserts early.
- Reset, on a wr_clk edge with rst=1, forces all of the following to 0 regardless of wr_req:
  - wr_bin, wr_gray, rd_s1, rd_s2, full, almost_full, wr_level, overflow.
  - wr_en is therefore 0 during reset.
- Reset mid-operation discards the pointer state. The read side must be reset in the same system reset event.

## Timing
- wr_en is combinational from wr_req and full in the same cycle. The RAM captures data on the same wr_clk edge that advances wrt_ptr.
- wrt_ptr, wr_ptr_gray, full, almost_full and wr_level all reflect an accepted push immediately after that push's edge.
- A write reaching the last free slot asserts full on that same edge. A back-to-back push on the next cycle is refused.
- Read-pointer visibility: a change on rd_ptr_gray affects full, almost_full and wr_level 2 wr_clk edges later. The flags register from rd_s2's D input.
- wr_ptr_gray changes at most one bit per wr_clk edge.
- A simultaneous push and read-pointer change on the same edge are both accounted for in the flags registered at that edge.
- Throughput: one push per cycle while not full.

## Test plan
All scenarios use SIZE=3 and AFULL_MARGIN=2.
- Reset: hold rst for 2 cycles with wr_req=1 → all outputs are 0 and wr_en=0 throughout.
- Fill: rd_ptr_gray=0, wr_req=1 for 9 cycles.
  - almost_full rises after the 6th write.
  - full rises after the 8th write, with wr_level=8 and wrt_ptr=0.
  - The 9th cycle has wr_en=0 and sets overflow; pointers do not move.
- Drain visibility: from full, set rd_ptr_gray=4'b0010 (binary 3) → full stays 1 for 1 edge, clears on the 2nd edge. wr_level=5, almost_full=0.
- Wrap: fill 8, set rd_ptr_gray=Gray(8)=4'b1100, wait 2 cycles, push 3.
  - wrt_ptr goes 0→1→2→3.
  - wr_bin goes 8→11, wr_ptr_gray ends at 4'b1110.
  - wr_level=3, full=0.
- Gray property: random pushes over 64 cycles → wr_ptr_gray Hamming distance between consecutive cycles ≤ 1, and it always equals Gray(wr_bin).
- Reset mid-fill: after 5 pushes assert rst for 1 cycle → all outputs are 0, overflow is cleared, and the next push writes wrt_ptr=0.
